serial_2_parallel: RTL and testbench



---
 rtl/serial_2_parallel.sv | 113 +++++++++++
 tb/tb_serial_2_parallel.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_2_parallel.sv
// rtl/serial_2_parallel.sv - MSB-first serial-to-parallel receiver with valid/ack handshake
//
// Purpose: collects DATA_WIDTH serial bits from Filter_Input on posedge spi_sck
// and presents each completed word on parallel_data, held under a valid/ack handshake.
// Optional feature macro: S2P_OVERRUN_EN enables the sticky overrun flag and overrun_clr.
//
// Ports:
//   spi_sck       in   serial clock, all state updates on posedge
//   rst           in   asynchronous active-high reset
//   Filter_Input  in   serial data, MSB first
//   frame_sync    in   marks this edge's bit as MSB of a new word
//   data_ack      in   consumer accepts the current word
//   overrun_clr   in   clears the sticky overrun flag
//   parallel_data out  last completed word
//   data_valid    out  parallel_data holds an unacknowledged word
//   overrun       out  sticky: a word completed while the previous was unacknowledged
module serial_2_parallel #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  spi_sck,
  input  logic                  rst,
  input  logic                  Filter_Input,
  input  logic                  frame_sync,
  input  logic                  data_ack,
  input  logic                  overrun_clr,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  data_valid,
  output logic                  overrun
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] parallel_data_q, parallel_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0] shifted;
  logic                  complete;
  logic                  overrun_event;

  always_comb begin
    shifted       = {shift_reg_q[DATA_WIDTH-2:0], Filter_Input};
    shift_reg_d   = shifted;
    bit_cnt_d     = bit_cnt_q + CW'(1);
    complete      = 1'b0;

    // frame_sync restarts the word with this edge's bit as MSB and
    // suppresses any completion that would otherwise land here.
    if (frame_sync) begin
      shift_reg_d = {{(DATA_WIDTH-1){1'b0}}, Filter_Input};
      bit_cnt_d   = CW'(1);
    end else if (bit_cnt_q == LAST_BIT) begin
      complete  = 1'b1;
      bit_cnt_d = '0;
    end

    parallel_data_d = complete ? shifted : parallel_data_q;

    // A completion keeps valid high even when acked on the same edge,
    // because the ack retires the old word and the new one takes its place.
    if (complete) begin
      data_valid_d = 1'b1;
    end else if (data_ack) begin
      data_valid_d = 1'b0;
    end else begin
      data_valid_d = data_valid_q;
    end

    overrun_event = complete & data_valid_q & ~data_ack;

`ifdef S2P_OVERRUN_EN
    // Set wins over clear on the same edge.
    if (overrun_event) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
`else
    overrun_d = 1'b0;
`endif
  end

`ifndef S2P_OVERRUN_EN
  logic unused_overrun_inputs;
  assign unused_overrun_inputs = overrun_clr ^ overrun_event;
`endif

  always_ff @(posedge spi_sck or posedge rst) begin
    if (rst) begin
      shift_reg_q     <= '0;
      bit_cnt_q       <= '0;
      parallel_data_q <= '0;
      data_valid_q    <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      shift_reg_q     <= shift_reg_d;
      bit_cnt_q       <= bit_cnt_d;
      parallel_data_q <= parallel_data_d;
      data_valid_q    <= data_valid_d;
      overrun_q       <= overrun_d;
    end
  end

  assign parallel_data = parallel_data_q;
  assign data_valid    = data_valid_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_serial_2_parallel.sv
// tb/tb_serial_2_parallel.sv - directed bench for serial_2_parallel
module tb_serial_2_parallel;

  logic        spi_sck = 1'b0;
  logic        rst;
  logic        Filter_Input;
  logic        frame_sync;
  logic        data_ack;
  logic        overrun_clr;
  logic [15:0] parallel_data;
  logic        data_valid;
  logic        overrun;

  int total  = 0;
  int passed = 0;

`ifdef S2P_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  serial_2_parallel #(.DATA_WIDTH(16)) dut (
    .spi_sck      (spi_sck),
    .rst          (rst),
    .Filter_Input (Filter_Input),
    .frame_sync   (frame_sync),
    .data_ack     (data_ack),
    .overrun_clr  (overrun_clr),
    .parallel_data(parallel_data),
    .data_valid   (data_valid),
    .overrun      (overrun)
  );

  always #5 spi_sck = ~spi_sck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drive one bit, let the posedge take it, then sample 1 time unit later.
  task automatic send_bit(input logic b, input logic fs, input logic ack, input logic clr);
    Filter_Input = b;
    frame_sync   = fs;
    data_ack     = ack;
    overrun_clr  = clr;
    @(posedge spi_sck);
    #1;
    Filter_Input = 1'b0;
    frame_sync   = 1'b0;
    data_ack     = 1'b0;
    overrun_clr  = 1'b0;
  endtask

  logic [15:0] w;

  initial begin
    rst = 1'b1; Filter_Input = 1'b0; frame_sync = 1'b0; data_ack = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(posedge spi_sck);
    #1;
    chk("reset_pd", parallel_data, 16'h0000);
    chk("reset_valid", data_valid, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    rst = 1'b0;

    // Word 0xA5C3 right after reset release.
    w = 16'hA5C3;
    for (int i = 0; i < 15; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0);
    chk("a5c3_valid_before_last", data_valid, 1'b0);
    send_bit(w[0], 1'b0, 1'b0, 1'b0);
    chk("a5c3_pd", parallel_data, 16'hA5C3);
    chk("a5c3_valid", data_valid, 1'b1);

    // 0x1234 with ack on its first edge: valid drops, then the new word lands.
    w = 16'h1234;
    send_bit(w[15], 1'b0, 1'b1, 1'b0);
    chk("b2b_valid_drop1", data_valid, 1'b0);
    for (int i = 1; i < 16; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0);
    chk("b2b_pd1", parallel_data, 16'h1234);
    chk("b2b_valid1", data_valid, 1'b1);
    chk("b2b_overrun1", overrun, 1'b0);

    w = 16'hFFFF;
    send_bit(w[15], 1'b0, 1'b1, 1'b0);
    chk("b2b_valid_drop2", data_valid, 1'b0);
    for (int i = 1; i < 16; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0);
    chk("b2b_pd2", parallel_data, 16'hFFFF);
    chk("b2b_valid2", data_valid, 1'b1);
    chk("b2b_overrun2", overrun, 1'b0);

    // 5 garbage bits (first one acks 0xFFFF), then frame_sync on MSB of 0x8001.
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sync_garbage_valid", data_valid, 1'b0);
    w = 16'h8001;
    send_bit(w[15], 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 15; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0);
    chk("sync_no_early_word", data_valid, 1'b0);
    chk("sync_pd_unchanged", parallel_data, 16'hFFFF);
    send_bit(w[0], 1'b0, 1'b0, 1'b0);
    chk("sync_pd", parallel_data, 16'h8001);
    chk("sync_valid", data_valid, 1'b1);

    // 0x0001 acks 0x8001 on its first edge; 0x0002 arrives unacked.
    w = 16'h0001;
    send_bit(w[15], 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0);
    chk("ovr_first_pd", parallel_data, 16'h0001);
    chk("ovr_first_overrun", overrun, 1'b0);
    w = 16'h0002;
    for (int i = 0; i < 16; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0);
    chk("ovr_pd", parallel_data, 16'h0002);
    chk("ovr_valid", data_valid, 1'b1);
    chk("ovr_flag", overrun, OVR_EXP);

    // overrun_clr on first bit of 0x00FF; ack coincides with its completion.
    w = 16'h00FF;
    send_bit(w[15], 1'b0, 1'b0, 1'b1);
    chk("clr_overrun", overrun, 1'b0);
    chk("clr_valid_held", data_valid, 1'b1);
    for (int i = 1; i < 15; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0);
    send_bit(w[0], 1'b0, 1'b1, 1'b0);
    chk("ackcomp_valid", data_valid, 1'b1);
    chk("ackcomp_pd", parallel_data, 16'h00FF);
    chk("ackcomp_overrun", overrun, 1'b0);

    // Reset after 8 bits of 0xBEEF; outputs clear before the next edge.
    w = 16'hBEEF;
    for (int i = 0; i < 8; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pd", parallel_data, 16'h0000);
    chk("async_rst_valid", data_valid, 1'b0);
    chk("async_rst_overrun", overrun, 1'b0);
    @(posedge spi_sck);
    #1;
    rst = 1'b0;
    w = 16'h0F0F;
    for (int i = 0; i < 15; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0);
    chk("post_rst_valid_before_last", data_valid, 1'b0);
    send_bit(w[0], 1'b0, 1'b0, 1'b0);
    chk("post_rst_pd", parallel_data, 16'h0F0F);
    chk("post_rst_valid", data_valid, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
